// File: rtl/mul_unit32_if.sv
// mul_unit32_if: start/ready handshake and operand/result bus of the iterative multiplier.
interface mul_unit32_if;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed_a;
    logic        is_signed_b;
    logic [63:0] out;
    logic        ready;
    modport master (output en, a, b, is_signed_a, is_signed_b, input out, ready);
    modport slave  (input en, a, b, is_signed_a, is_signed_b, output out, ready);
endinterface

// File: rtl/mul_unit32.sv
// mul_unit32: multi-cycle 32x32->64 signed/unsigned shift-add multiplier with sign-fix cycle.
// Define MULT_EARLY_EXIT_EN to leave BUSY as soon as the remaining multiplier magnitude is zero.
module mul_unit32 #(
    parameter int STEP_BITS = 1
) (
    input logic clk,
    input logic rst,
    mul_unit32_if.slave bus
);
    localparam int N = 32 / STEP_BITS;
    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
    state_t      state;
    logic        sa, sb;
    logic [31:0] mag_a, rem_b;
    logic [63:0] acc, out_q;
    logic        ready_q;
    logic [5:0]  cnt;
    logic [31:0] abs_a, abs_b;
    logic [63:0] partial;
    logic        last;
    always_comb begin
        abs_a = (bus.is_signed_a && bus.a[31]) ? -bus.a : bus.a;
        abs_b = (bus.is_signed_b && bus.b[31]) ? -bus.b : bus.b;
        partial = (64'(mag_a) * 64'(rem_b[STEP_BITS-1:0])) << (32'(cnt) * STEP_BITS);
`ifdef MULT_EARLY_EXIT_EN
        last = (rem_b == '0) || (cnt == 6'(N - 1));
`else
        last = cnt == 6'(N - 1);
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= 1'b0;
            sb      <= 1'b0;
            mag_a   <= '0;
            rem_b   <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.en) begin
                    sa      <= bus.is_signed_a & bus.a[31];
                    sb      <= bus.is_signed_b & bus.b[31];
                    mag_a   <= abs_a;
                    rem_b   <= abs_b;
                    acc     <= '0;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                    state   <= BUSY;
                end
                BUSY: begin
                    acc   <= acc + partial;
                    rem_b <= rem_b >> STEP_BITS;
                    cnt   <= cnt + 6'd1;
                    state <= last ? FIX : BUSY;
                end
                FIX: begin
                    out_q   <= (sa ^ sb) ? -acc : acc;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.out   = out_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_mul_unit32.sv
// tb_mul_unit32: randomized self-checking bench against a wide-arithmetic product model.
module tb_mul_unit32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mul_unit32_if bus();
    mul_unit32 #(.STEP_BITS(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
        logic signed [65:0] ea, eb, p;
        ea = {{34{sa & a[31]}}, a};
        eb = {{34{sb & b[31]}}, b};
        p = ea * eb;
        return p[63:0];
    endfunction

    // glitch >= 0 pulses en with junk operands at that BUSY cycle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                          input logic sb, input string tag, input int glitch);
        int lat;
        logic [63:0] exp;
        exp = ref_mul(a, b, sa, sb);
        @(negedge clk);
        bus.en = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.is_signed_a = sa;
        bus.is_signed_b = sb;
        @(posedge clk);
        #1;
        check({tag, "_rdy_drop"}, 64'(bus.ready), 64'd0);
        bus.en = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.is_signed_a = 1'($urandom);
        bus.is_signed_b = 1'($urandom);
        lat = 0;
        while (!bus.ready && lat < 40) begin
            bus.en = (lat == glitch);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.en = 1'b0;
`ifdef MULT_EARLY_EXIT_EN
        check({tag, "_lat"}, 64'(lat >= 2 && lat <= 33), 64'd1);
`else
        check({tag, "_lat"}, 64'(lat), 64'd33);
`endif
        check({tag, "_out"}, bus.out, exp);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.is_signed_a = 1'b0;
        bus.is_signed_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bus.out, 64'd0);
        check("reset_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "uu_max", -1);
        check("uu_max_const", bus.out, 64'hFFFFFFFE00000001);
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, "ss_min", -1);
        check("ss_min_const", bus.out, 64'h4000000000000000);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, "ss_m1", -1);
        check("ss_m1_const", bus.out, 64'd1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, "su", -1);
        check("su_const", bus.out, 64'hFFFFFFFF00000001);
        run_op(32'd2, 32'h80000000, 1'b0, 1'b1, "us", -1);
        check("us_const", bus.out, 64'hFFFFFFFF00000000);
        run_op(32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, "zero_a", -1);
        check("zero_a_const", bus.out, 64'd0);
        run_op(32'h80000000, 32'd0, 1'b1, 1'b1, "zero_b", -1);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, "en_busy", 5);
        // abort at BUSY cycle 10
        @(negedge clk);
        bus.en = 1'b1;
        bus.a = 32'hDEADBEEF;
        bus.b = 32'h0BADF00D;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out", bus.out, 64'd0);
        check("abort_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_stays_idle", 64'(bus.ready), 64'd0);
        run_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b1, "post_abort", -1);
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 150; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 7))
                    0: ra = 32'h80000000;
                    1: rb = 32'hFFFFFFFF;
                    2: rb = 32'd0;
                    3: ra = 32'hFFFFFFFF;
                    default: ;
                endcase
                run_op(ra, rb, m[1], m[0], "rand", -1);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
